// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
//   Takes the LED pattern from the scroll stage and drives the board LEDs through
//   per-channel 4-bit PWM brightness. Each channel's level moves one step per
//   fade tick: up toward 15 when its pattern bit is 1, down toward 0 when it is 0.
//   A shifted pattern therefore leaves a fading trail behind it. When bypass is
//   high, the pattern goes straight to the LEDs, for debug.
//
//   Timing chain (all counters free-running):
//     div_cnt  0..PWM_DIV-1       -> slot_tick   (one PWM slot)
//     pwm_cnt  0..15              -> period_tick (16 slots = one PWM period)
//     fade_cnt 0..FADE_PERIODS-1  -> fade_tick   (one brightness step)
//
// Ports
//   clk      in   1      single clock, all logic on its rising edge
//   reset    in   1      synchronous, active-high reset
//   bypass   in   1      1: led_out follows led_in, with no PWM and no fading
//   led_in   in   N_LED  target pattern, 1 = LED on
//   led_out  out  N_LED  registered LED drive, 1 = LED lit
// -----------------------------------------------------------------------------
module led_pwm_fader #(
  parameter int N_LED        = 16,
  parameter int PWM_DIV      = 8,   // legal 1..65535
  parameter int FADE_PERIODS = 4    // legal 1..255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bypass,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out
);

  localparam logic [15:0] DIV_LAST  = 16'(PWM_DIV - 1);
  localparam logic [7:0]  FADE_LAST = 8'(FADE_PERIODS - 1);
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

  logic [15:0] div_cnt;
  logic [3:0]  pwm_cnt;
  logic [7:0]  fade_cnt;
  logic [3:0]  level [N_LED];

  logic slot_tick;
  logic period_tick;
  logic fade_tick;

  assign slot_tick   = (div_cnt == DIV_LAST);
  assign period_tick = slot_tick && (pwm_cnt == LEVEL_MAX);
  assign fade_tick   = period_tick && (fade_cnt == FADE_LAST);

  // NOTE: all state below is updated with non-blocking assignments, so every
  // expression in this block sees the values from before the clock edge. The
  // output compare therefore uses the level and pwm_cnt of the current cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pwm_cnt  <= '0;
      fade_cnt <= '0;
      led_out  <= '0;
      // NOTE: the level array is a set of flops, not a RAM, so it can be reset
      // like any other register. The fade must restart from dark.
      for (int i = 0; i < N_LED; i++) begin
        level[i] <= '0;
      end
    end else begin
      div_cnt <= slot_tick ? '0 : div_cnt + 16'd1;

      if (slot_tick) begin
        pwm_cnt <= pwm_cnt + 4'd1;  // wraps 15 -> 0 naturally
      end

      if (period_tick) begin
        fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 8'd1;
      end

      for (int i = 0; i < N_LED; i++) begin
        if (bypass) begin
          // Set the level to fully on or fully off, so that leaving bypass
          // continues from the same visible state with no glitch. Bypass takes
          // priority over a fade step in the same cycle.
          level[i]   <= {4{led_in[i]}};
          led_out[i] <= led_in[i];
        end else begin
          if (fade_tick) begin
            if (led_in[i] && level[i] != LEVEL_MAX) begin
              level[i] <= level[i] + 4'd1;
            end else if (!led_in[i] && level[i] != 4'd0) begin
              level[i] <= level[i] - 4'd1;
            end
          end
          // Level k lights slots 0..k-1. Level 15 is forced fully on; otherwise
          // it would be dark for one slot in 16.
          led_out[i] <= (level[i] == LEVEL_MAX) || (level[i] > pwm_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
//   Directed bench for led_pwm_fader with PWM_DIV=2 and FADE_PERIODS=1, so one
//   PWM period is 32 clocks and the level steps once per period.
//
//   Timing reference: the first rising edge after reset is released is edge 1.
//   The first fade step happens on edge 32. led_out is registered, so window m
//   (edges 32m+1 .. 32m+32) shows a steady level. Within that window, led_out
//   is high on samples 0..2k-1 for level k (1..14), low on every sample for
//   level 0, and high on every sample for level 15.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int N_LED = 16;

  logic             clk;
  logic             reset;
  logic             bypass;
  logic [N_LED-1:0] led_in;
  logic [N_LED-1:0] led_out;

  int n_checks;
  int n_pass;

  led_pwm_fader #(
    .N_LED       (N_LED),
    .PWM_DIV     (2),
    .FADE_PERIODS(1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bypass (bypass),
    .led_in (led_in),
    .led_out(led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a hung run. The directed sequence itself is only ~2000 clocks.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock. Return at the following falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sample one 32-clock window on channel 0 and compare it with the pattern for level lvl.
  // The other channels are expected to stay dark.
  task automatic window(input int lvl, input string tag);
    logic [31:0] pat;
    logic [31:0] exp_pat;
    logic        upper_lit;
    pat       = '0;
    upper_lit = 1'b0;
    for (int j = 0; j < 32; j++) begin
      step();
      pat[j]    = led_out[0];
      upper_lit = upper_lit | (|led_out[N_LED-1:1]);
    end
    if (lvl >= 15)     exp_pat = 32'hFFFF_FFFF;
    else if (lvl <= 0) exp_pat = 32'h0000_0000;
    else               exp_pat = (32'd1 << (2 * lvl)) - 32'd1;
    check(tag, pat, exp_pat);
    check({tag, "_upper"}, {31'd0, upper_lit}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bypass   = 1'b0;
    led_in   = 16'hFFFF;

    // 1. Reset while led_in is all ones. The outputs must be dark after the reset edge.
    step();
    check("reset_out", {16'd0, led_out}, 32'h0000_0000);
    step();
    check("reset_out_hold", {16'd0, led_out}, 32'h0000_0000);

    // 2. Ramp channel 0 up: level m in window m, saturating at 15.
    led_in = 16'h0001;
    reset  = 1'b0;
    for (int m = 0; m <= 16; m++) begin
      // 3. Window 8 is the level-8 case: high for exactly 16 of 32 clocks.
      window(m, $sformatf("ramp_up_w%0d", m));
    end

    // 4. Ramp down from 15. The first step down happens at the end of window 17, then
    //    the level stays at 0 with no wrap.
    led_in = 16'h0000;
    for (int w = 17; w <= 34; w++) begin
      window(15 - (w - 17), $sformatf("ramp_down_w%0d", w));
    end

    // 5. Bypass: led_out follows led_in after one cycle. Leaving bypass is glitch-free.
    bypass = 1'b1;
    led_in = 16'hA5A5;
    step();
    check("bypass_first", {16'd0, led_out}, 32'h0000_A5A5);
    for (int k = 0; k < 5; k++) step();
    check("bypass_hold", {16'd0, led_out}, 32'h0000_A5A5);
    bypass = 1'b0;
    begin
      int glitches;
      glitches = 0;
      for (int k = 0; k < 70; k++) begin
        step();
        if (led_out !== 16'hA5A5) glitches++;
      end
      check("bypass_exit_glitches", glitches, 32'd0);
    end
    step();
    check("bypass_exit_value", {16'd0, led_out}, 32'h0000_A5A5);

    // 6. Reset in the middle of a fade, while level[0] is 7.
    led_in = 16'h0000;
    reset  = 1'b1;
    step();
    check("reset2_out", {16'd0, led_out}, 32'h0000_0000);
    reset  = 1'b0;
    led_in = 16'h0001;
    for (int m = 0; m < 7; m++) begin
      window(m, $sformatf("refade_w%0d", m));
    end
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    step();
    check("midfade_reset_out", {16'd0, led_out}, 32'h0000_0000);
    reset = 1'b0;
    // After the reset, the level restarts at 0 and the first step lands 32 clocks
    // after release.
    window(0, "post_reset_w0");
    window(1, "post_reset_w1");
    window(2, "post_reset_w2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
